// File: rtl/tetris_line_clear_if.sv
// Board-side bus of the line-clear sequencer: controller handshake plus the
// synchronous board RAM read/write ports.
interface tetris_line_clear_if #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int CNT_W  = $clog2(ROWS + 1)
) ();
  // Handshake: start is a level request that is only honoured while the
  // sequencer is idle (busy=0, done=0); done is a single-cycle completion
  // pulse. rd_data must carry the row addressed by rd_addr one cycle after
  // rd_en; a write lands on the clock edge that samples wr_en.
  logic              start;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  lines_cleared;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COLS-1:0]   rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [COLS-1:0]   wr_data;

  modport master (
    output start,
    output rd_data,
    input  busy,
    input  done,
    input  lines_cleared,
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  start,
    input  rd_data,
    output busy,
    output done,
    output lines_cleared,
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/tetris_line_clear.sv
// Bottom-up line-clear sequencer: reads each board row, drops full rows by
// copying survivors down, then zero-fills the vacated top rows.
module tetris_line_clear #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int CNT_W  = $clog2(ROWS + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  tetris_line_clear_if.slave  bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [COLS-1:0]   wr_data_c;
  logic              row_full;

  assign row_full = &bus.rd_data;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    w_d       = w_q;
    k_d       = k_q;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    wr_data_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          r_d     = LAST_ROW;
          w_d     = LAST_ROW;
          k_d     = '0;
        end
      end

      READ: state_d = CHECK;

      CHECK: begin
        if (row_full) begin
          k_d = k_q + CNT_W'(1);
        end else begin
          // Surviving row already in place needs no copy.
          if (w_q != r_q) begin
            wr_en_c   = 1'b1;
            wr_addr_c = w_q;
            wr_data_c = bus.rd_data;
          end
          w_d = w_q - ADDR_W'(1);
        end

        if (r_q == '0) begin
          state_d = (k_d != '0) ? FILL : DONE;
        end else begin
          r_d     = r_q - ADDR_W'(1);
          state_d = READ;
        end
      end

      // After the scan w points at row k-1, the highest vacated row.
      FILL: begin
        wr_en_c   = 1'b1;
        wr_addr_c = w_q;
        wr_data_c = '0;
        w_d       = w_q - ADDR_W'(1);
        if (w_q == '0) begin
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Status and read strobes are registered from the next state so they line
  // up with the state they describe.
  always_comb begin
    busy_d    = (state_d == READ) || (state_d == CHECK) || (state_d == FILL);
    done_d    = (state_d == DONE);
    rd_en_d   = (state_d == READ);
    rd_addr_d = (state_d == READ) ? r_d : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      r_q       <= '0;
      w_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      w_q       <= w_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Strobes are suppressed during reset so an aborted scan touches nothing more.
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = k_q;
  assign bus.rd_en         = rd_en_q & ~Reset;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.wr_en         = wr_en_c & ~Reset;
  assign bus.wr_addr       = wr_addr_c;
  assign bus.wr_data       = wr_data_c;
  assign dbg_state         = state_q;

  a_no_raw_hazard : assert property (@(posedge Clk) disable iff (Reset)
    (state_q == CHECK) |-> (w_q >= r_q));

  a_count_bound : assert property (@(posedge Clk) disable iff (Reset)
    (k_q <= CNT_W'(ROWS)));

  a_single_port_use : assert property (@(posedge Clk) disable iff (Reset)
    !(bus.rd_en && bus.wr_en));

endmodule

// File: tb/tb_tetris_line_clear.sv
// Bench for tetris_line_clear: board RAM model, directed and random boards,
// checked against a queue-based compaction model.
module tb_tetris_line_clear;
  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int ADDR_W = $clog2(ROWS);
  localparam int CNT_W  = $clog2(ROWS + 1);

  logic       Clk;
  logic       Reset;
  logic [2:0] dbg_state;

  tetris_line_clear_if #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  tetris_line_clear #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // board RAM with one-cycle read latency
  logic [COLS-1:0] mem        [ROWS];
  logic [COLS-1:0] board_init [ROWS];
  logic            load_board;
  logic [COLS-1:0] rd_q;

  always @(posedge Clk) begin
    if (load_board) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= board_init[i];
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.rd_en) rd_q <= mem[bus.rd_addr];
  end
  assign bus.rd_data = rd_q;

  int n_checks;
  int n_fail;

  // reference model results
  logic [COLS-1:0] exp_board [ROWS];
  int              exp_k;
  int              exp_writes;

  task automatic model_clear();
    logic [COLS-1:0] surv_q[$];
    int              orig_q[$];
    logic [COLS-1:0] full_row;
    full_row = '1;
    surv_q.delete();
    orig_q.delete();
    for (int i = 0; i < ROWS; i++) begin
      if (board_init[i] != full_row) begin
        surv_q.push_back(board_init[i]);
        orig_q.push_back(i);
      end
    end
    exp_k      = ROWS - surv_q.size();
    exp_writes = exp_k;
    for (int i = 0; i < ROWS; i++) exp_board[i] = '0;
    for (int j = 0; j < surv_q.size(); j++) begin
      exp_board[exp_k + j] = surv_q[j];
      if (orig_q[j] != exp_k + j) exp_writes++;
    end
  endtask

  task automatic load_mem();
    @(negedge Clk);
    load_board = 1'b1;
    @(negedge Clk);
    load_board = 1'b0;
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    bus.start  = 1'b0;
    load_board = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: busy/done/rd_en/wr_en=%b expected 0000",
               {bus.busy, bus.done, bus.rd_en, bus.wr_en});
    end
    n_checks++;
    if ({bus.lines_cleared, bus.rd_addr, bus.wr_addr, bus.wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: lines_cleared=%0d rd_addr=%0d wr_addr=%0d wr_data=%h expected all 0",
               bus.lines_cleared, bus.rd_addr, bus.wr_addr, bus.wr_data);
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_board_scan(input string name);
    int   cyc;
    int   done_cyc;
    int   writes;
    int   busy_bad;
    int   row_bad;
    int   budget;
    logic exp_busy;
    logic [CNT_W-1:0] lc_first;
    model_clear();
    load_mem();
    @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    writes   = 0;
    busy_bad = 0;
    budget   = 3 * ROWS + 10;
    lc_first = bus.lines_cleared;
    while (done_cyc < 0 && cyc <= budget) begin
      if (bus.wr_en === 1'b1) writes++;
      exp_busy = (cyc <= 2 * ROWS + exp_k);
      if (bus.busy !== exp_busy) busy_bad++;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        @(negedge Clk);
        cyc++;
      end
    end
    n_checks++;
    if (done_cyc != 2 * ROWS + exp_k + 1) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected %0d (-1 = timeout)", name, done_cyc, 2 * ROWS + exp_k + 1);
    end
    n_checks++;
    if (lc_first !== '0) begin
      n_fail++;
      $display("FAIL %s lines_cleared_cycle1: got %0d expected 0", name, lc_first);
    end
    n_checks++;
    if (bus.lines_cleared !== CNT_W'(exp_k)) begin
      n_fail++;
      $display("FAIL %s lines_cleared: got %0d expected %0d", name, bus.lines_cleared, exp_k);
    end
    n_checks++;
    if (writes != exp_writes) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, writes, exp_writes);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_profile: got %0d bad cycles expected 0", name, busy_bad);
    end
    row_bad = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (mem[i] !== exp_board[i]) begin
        if (row_bad == 0)
          $display("FAIL %s board_row%0d: got %h expected %h", name, i, mem[i], exp_board[i]);
        row_bad++;
      end
    end
    n_checks++;
    if (row_bad != 0) begin
      n_fail++;
      $display("FAIL %s board: got %0d wrong rows expected 0", name, row_bad);
    end
    repeat (3) @(negedge Clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.lines_cleared !== CNT_W'(exp_k)) begin
      n_fail++;
      $display("FAIL %s idle_hold: done=%b lines_cleared=%0d expected done=0 lines_cleared=%0d",
               name, bus.done, bus.lines_cleared, exp_k);
    end
  endtask

  task automatic test_directed_boards();
    for (int i = 0; i < ROWS; i++) board_init[i] = '0;
    test_board_scan("empty");

    for (int i = 0; i < ROWS; i++) board_init[i] = COLS'($urandom_range(0, (1 << COLS) - 2));
    board_init[ROWS-1] = '1;
    test_board_scan("bottom_full");

    for (int i = 0; i < ROWS; i++) board_init[i] = COLS'(i + 1);
    board_init[19] = '1;
    board_init[17] = '1;
    board_init[16] = '1;
    board_init[10] = '1;
    test_board_scan("four_full");

    for (int i = 0; i < ROWS; i++) board_init[i] = COLS'(3 * i + 5);
    board_init[0] = '1;
    test_board_scan("top_full");

    for (int i = 0; i < ROWS; i++) board_init[i] = '1;
    test_board_scan("all_full");
  endtask

  task automatic test_random_boards();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < ROWS; i++) begin
        if ($urandom_range(0, 3) == 0) board_init[i] = '1;
        else board_init[i] = COLS'($urandom_range(0, (1 << COLS) - 2));
      end
      test_board_scan($sformatf("random%0d", t));
    end
  endtask

  task automatic test_start_held();
    int dones;
    int exp_done;
    int cyc;
    int second_done;
    logic busy_idle;
    logic busy_restart;
    for (int i = 0; i < ROWS; i++) begin
      if ($urandom_range(0, 2) == 0) board_init[i] = '1;
      else board_init[i] = COLS'($urandom_range(0, (1 << COLS) - 2));
    end
    model_clear();
    load_mem();
    @(negedge Clk);
    bus.start = 1'b1;
    exp_done  = 2 * ROWS + exp_k + 1;
    dones     = 0;
    busy_idle = 1'bx;
    busy_restart = 1'bx;
    for (int c = 1; c <= exp_done + 2; c++) begin
      @(negedge Clk);
      if (c <= exp_done + 1 && bus.done === 1'b1) dones++;
      if (c == exp_done + 1) busy_idle = bus.busy;
      if (c == exp_done + 2) busy_restart = bus.busy;
    end
    bus.start = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL start_held done_pulses: got %0d expected 1", dones);
    end
    n_checks++;
    if (busy_idle !== 1'b0 || busy_restart !== 1'b1) begin
      n_fail++;
      $display("FAIL start_held restart: busy after done=%b,%b expected 0,1", busy_idle, busy_restart);
    end
    // the second scan sees an already compacted board
    cyc = 1;
    second_done = -1;
    while (second_done < 0 && cyc <= 100) begin
      if (bus.done === 1'b1) second_done = cyc;
      else begin
        @(negedge Clk);
        cyc++;
      end
    end
    n_checks++;
    if (second_done != 2 * ROWS + 1 || bus.lines_cleared !== '0) begin
      n_fail++;
      $display("FAIL start_held second_scan: done cycle %0d lines_cleared %0d expected %0d and 0",
               second_done, bus.lines_cleared, 2 * ROWS + 1);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset_mid_scan();
    int bad;
    logic [CNT_W-1:0] lc_before;
    for (int i = 0; i < ROWS; i++) board_init[i] = COLS'(i);
    board_init[19] = '1;
    board_init[18] = '1;
    load_mem();
    @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (14) @(negedge Clk);
    lc_before = bus.lines_cleared;
    n_checks++;
    if (lc_before !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL reset_mid lines_before: got %0d expected 2", lc_before);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if ({bus.busy, bus.rd_en, bus.wr_en} !== 3'b000 || bus.lines_cleared !== '0) begin
      n_fail++;
      $display("FAIL reset_mid after: busy/rd_en/wr_en=%b lines_cleared=%0d expected 000 and 0",
               {bus.busy, bus.rd_en, bus.wr_en}, bus.lines_cleared);
    end
    Reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge Clk);
      if (bus.done !== 1'b0 || bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    load_board = 1'b0;
    bus.start  = 1'b0;
    Reset      = 1'b1;
    test_reset();
    test_directed_boards();
    test_random_boards();
    test_start_held();
    test_reset_mid_scan();
    test_board_scan("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tetris_line_clear.md
# tetris_line_clear

Line-clear sequencer for the Tetris board memory. It runs while the game controller is in the check-lines state. On `start` it scans every board row from bottom to top, removes full rows by compacting the surviving rows downward, and zero-fills the vacated top rows. It then pulses `done`, which drives the controller's `line_scan_done`, and reports how many lines were cleared for scoring.

## Interface
Parameters:
- `ROWS`, default 20: number of board rows. Row 0 is the top row and row ROWS-1 is the bottom row.
- `COLS`, default 10: row width in cells. One bit per cell; 1 means occupied.
- `ADDR_W`, default `$clog2(ROWS)`: row address width.
- `CNT_W`, default `$clog2(ROWS+1)`: width of the cleared-line count.

Ports:
- `Clk`, input, 1: the single clock for the block.
- `Reset`, input, 1: synchronous reset, active-high.
- `start`, input, 1: request one scan. Sampled only in IDLE.
- `busy`, output, 1: high in READ, CHECK and FILL.
- `done`, output, 1: one-cycle pulse when the scan is complete.
- `lines_cleared`, output, CNT_W: number of full rows removed by the last scan.
- `rd_en`, output, 1: board read strobe.
- `rd_addr`, output, ADDR_W: row to read.
- `rd_data`, input, COLS: row contents. Valid in the cycle after `rd_en`/`rd_addr` (synchronous RAM).
- `wr_en`, output, 1: board write strobe.
- `wr_addr`, output, ADDR_W: row to write.
- `wr_data`, output, COLS: row contents to write.

## Operation
Internal registers:
- read pointer `r`
- write pointer `w`
- cleared count `k`

States:
- **IDLE**
  - `start`=1: set `r`=`w`=ROWS-1, set `k`=0 (so `lines_cleared` reads 0 from the next cycle), go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - Drive `rd_en`=1 and `rd_addr`=`r`.
  - Go to CHECK.
- **CHECK** (`rd_data` holds row `r`)
  - Row full (`&rd_data`): `k` += 1; `w` unchanged.
  - Row not full: if `w`≠`r`, issue a write with `wr_en`=1, `wr_addr`=`w`, `wr_data`=`rd_data`; no write when `w`==`r`. Then `w` -= 1.
  - If `r`==0, go to FILL when `k`>0, or to DONE when `k`==0.
  - Otherwise `r` -= 1 and go to READ.
- **FILL**
  - Write zeros to rows `k`-1 down to 0, one row per cycle (`wr_data`=0).
  - After row 0 is written, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.

Boundary conditions:
- Invariant: `w` ≥ `r` throughout the scan. Any address written in CHECK is strictly greater than every row still to be read, so there is no read-after-write hazard and no bypass is needed.
- `start` is ignored while `busy` or in DONE; it is not queued.
- `lines_cleared` holds its value through IDLE until the next accepted `start`.
- All rows full: `k`=ROWS, with no CHECK writes; FILL zeroes every row.
- `k` never exceeds ROWS; CNT_W is sized so the count cannot wrap.
- `rd_en` and `wr_en` are never both asserted for the same address in the same cycle.
- Outputs not listed as active in a state are held at 0: `rd_en`, `wr_en`, `done`, and the addresses/data.

Reset:
- Reset values: state=IDLE, `busy`=0, `done`=0, `lines_cleared`=0, `rd_en`=0, `wr_en`=0, `rd_addr`=0, `wr_addr`=0, `wr_data`=0.
- Reset mid-scan returns to IDLE on the next edge with no further reads or writes and no `done` pulse. Board contents may be partially compacted; reinitialising the board is the game controller's responsibility.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Scan: cycles 1 … 2·ROWS, alternating READ and CHECK, 2 cycles per row.
- Fill: cycles 2·ROWS+1 … 2·ROWS+`k`.
- `done` is high in cycle 2·ROWS+`k`+1. With ROWS=20: cycle 41 when `k`=0, cycle 45 when `k`=4.
- `busy` rises in cycle 1 and is low in the DONE cycle.
- `lines_cleared` is final by the DONE cycle.
- The earliest next `start` is accepted in the cycle after DONE.
- Throughput: at most one read and one write per cycle.

## Test plan
- **Empty board**, `start`: no writes, `lines_cleared`=0, `done` in cycle 41, `busy` high in cycles 1–40.
- **Row 19 full, rows 0–18 random**: old rows 18..0 appear in rows 19..1, row 0=0, `lines_cleared`=1, `done` in cycle 42.
- **Rows 19, 17, 16, 10 full**, others distinct patterns: surviving rows stay in order and are packed to the bottom, rows 0–3=0, `lines_cleared`=4, `done` in cycle 45.
- **Only row 0 full**: no CHECK writes, one FILL write of row 0=0, `lines_cleared`=1, `done` in cycle 42.
- **`start` held high through an entire scan**: exactly one `done` pulse, and a second scan begins only after `start` is sampled in IDLE.
- **`Reset` asserted in cycle 15 of a scan**: next cycle `busy`=0, `lines_cleared`=0, `rd_en`=`wr_en`=0, and no `done` pulse ever appears.
